// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// div_unit_if
// Request/response handshake bundle for the iterative divide unit.
// Revision: 1.0
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       div_op_i;
    logic [WIDTH-1:0] in1_i;
    logic [WIDTH-1:0] in2_i;
    logic             kill_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] out_o;

    modport master (
        output valid_i, div_op_i, in1_i, in2_i, kill_i, ready_i,
        input  ready_o, valid_o, out_o
    );

    modport slave (
        input  valid_i, div_op_i, in1_i, in2_i, kill_i, ready_i,
        output ready_o, valid_o, out_o
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// div_unit
// Iterative restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Revision: 1.0
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk_i,
    input  logic     reset_ni,
    div_unit_if.slave bus
);
    localparam int                c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]   c_int_min  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIXUP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_out;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_op_quo;
    logic               r_q_neg;
    logic               r_r_neg;

    logic               w_is_quo;
    logic               w_is_signed;
    logic               w_sign1;
    logic               w_sign2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic               w_div_zero;
    logic               w_overflow;
    logic               w_accept;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;

    // Operand decode: bit 1 selects remainder, bit 0 selects unsigned.
    assign w_is_quo    = ~bus.div_op_i[1];
    assign w_is_signed = ~bus.div_op_i[0];
    assign w_sign1     = w_is_signed & bus.in1_i[WIDTH-1];
    assign w_sign2     = w_is_signed & bus.in2_i[WIDTH-1];
    assign w_abs1      = w_sign1 ? -bus.in1_i : bus.in1_i;
    assign w_abs2      = w_sign2 ? -bus.in2_i : bus.in2_i;
    assign w_div_zero  = (bus.in2_i == '0);
    assign w_overflow  = w_is_signed && (bus.in1_i == c_int_min) && (bus.in2_i == '1);
    assign w_accept    = bus.valid_i && (r_state == S_IDLE) && !bus.kill_i;

    // One extra bit keeps the shifted partial remainder exact for divisors above 2^(WIDTH-1).
    assign w_trial    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_divisor};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_div_zero || w_overflow) ? S_DONE : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_FIXUP;
                end
            end
            S_FIXUP: w_state_next = S_DONE;
            S_DONE: begin
                if (bus.ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (bus.kill_i) begin
            w_state_next = S_IDLE;
        end
    end

    // Datapath freezes under kill so out_o retains the last presented result.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_out     <= '0;
            r_cnt     <= '0;
            r_op_quo  <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
        end else if (!bus.kill_i) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_quo  <= w_is_quo;
                        r_q_neg   <= w_sign1 ^ w_sign2;
                        r_r_neg   <= w_sign1;
                        r_divisor <= w_abs2;
                        r_rem     <= '0;
                        r_quo     <= w_abs1;
                        r_cnt     <= '0;
                        if (w_div_zero) begin
                            r_out <= w_is_quo ? '1 : bus.in1_i;
                        end else if (w_overflow) begin
                            r_out <= w_is_quo ? bus.in1_i : '0;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + c_cnt_one;
                end
                S_FIXUP: begin
                    if (r_op_quo) begin
                        r_out <= r_q_neg ? -r_quo : r_quo;
                    end else begin
                        r_out <= r_r_neg ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o = (r_state == S_IDLE);
    assign bus.valid_o = (r_state == S_DONE);
    assign bus.out_o   = r_out;
endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// tb_div_unit
// Directed-vector scoreboard bench for div_unit.
// Revision: 1.0
// ============================================================================
module tb_div_unit;
    localparam int W        = 32;
    localparam int LAT_DIV  = W + 1;  // edges after the accept edge until valid_o rises
    localparam int LAT_FAST = 0;      // special cases are presented right after the accept edge

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    typedef struct {
        logic [W-1:0] val;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   first_cyc = 0;
    logic prev_v    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1 && !prev_v) first_cyc = cyc;
        prev_v = (bus.valid_o === 1'b1);
        if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%08h expected no result", bus.out_o);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " value"}, bus.out_o, mon_e.val);
                check({mon_e.name, " latency"}, W'(first_cyc - mon_e.acc), W'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_v, input int lat, input string name,
                         input bit push, output int acc);
        int guard;
        guard = 0;
        acc   = -1;
        @(posedge clk); #1;
        bus.valid_i  = 1'b1;
        bus.div_op_i = op;
        bus.in1_i    = a;
        bus.in2_i    = b;
        while (bus.ready_o !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s accept_timeout: ready_o=%b expected 1", name, bus.ready_o);
            bus.valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        if (push) sb.push_back('{exp_v, lat, acc, name});
        // Scramble inputs: the result must depend only on the accept-edge sample.
        bus.valid_i  = 1'b0;
        bus.div_op_i = 2'($urandom);
        bus.in1_i    = $urandom;
        bus.in2_i    = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic kill_at_ten(input bit use_reset, input logic [W-1:0] out_exp, input string name);
        int acc;
        issue(OP_DIVU, 32'd1000, 32'd7, '0, 0, name, 1'b0, acc);
        repeat (9) @(posedge clk);
        #1;
        if (use_reset) reset_n = 1'b0;
        else           bus.kill_i = 1'b1;
        @(posedge clk); #1;
        reset_n    = 1'b1;
        bus.kill_i = 1'b0;
        check({name, " ready_o"}, W'(bus.ready_o), W'(1));
        check({name, " valid_o"}, W'(bus.valid_o), W'(0));
        check({name, " out_o"}, bus.out_o, out_exp);
        repeat (40) @(posedge clk);
        #1;
        check({name, " still_idle"}, W'(bus.ready_o), W'(1));
    endtask

    initial begin
        int acc;
        int guard;
        bus.valid_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.ready_i  = 1'b1;
        bus.div_op_i = 2'd0;
        bus.in1_i    = '0;
        bus.in2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid_o", W'(bus.valid_o), W'(0));
        check("reset out_o", bus.out_o, '0);
        check("reset ready_o", W'(bus.ready_o), W'(1));
        reset_n = 1'b1;

        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_DIV, "divu_100_7", 1'b1, acc);
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, LAT_DIV, "remu_100_7", 1'b1, acc);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_DIV, "div_m7_2", 1'b1, acc);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_DIV, "rem_m7_2", 1'b1, acc);
        issue(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_DIV, "rem_7_m2", 1'b1, acc);
        issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST, "div_5_0", 1'b1, acc);
        issue(OP_REMU, 32'd5, 32'd0, 32'd5, LAT_FAST, "remu_5_0", 1'b1, acc);
        issue(OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, LAT_FAST, "divu_0_0", 1'b1, acc);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST, "div_ovf", 1'b1, acc);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FAST, "rem_ovf", 1'b1, acc);
        issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_DIV, "divu_ovf_ops", 1'b1, acc);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_DIV, "divu_max_1", 1'b1, acc);
        issue(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, LAT_DIV, "remu_wide", 1'b1, acc);
        issue(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, LAT_DIV, "div_m100_m7", 1'b1, acc);
        issue(OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, LAT_DIV, "rem_m100_m7", 1'b1, acc);
        drain();

        // Consumer stall: result held, new requests ignored.
        bus.ready_i = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_DIV, "divu_stall", 1'b1, acc);
        guard = 0;
        while (bus.valid_o !== 1'b1 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        check("stall valid_seen", W'(bus.valid_o), W'(1));
        bus.valid_i  = 1'b1;
        bus.div_op_i = OP_DIV;
        bus.in1_i    = 32'd5;
        bus.in2_i    = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall valid_o", W'(bus.valid_o), W'(1));
            check("stall out_o", bus.out_o, 32'd14);
            check("stall ready_o", W'(bus.ready_o), W'(0));
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, LAT_DIV, "after_stall", 1'b1, acc);
        drain();

        kill_at_ten(1'b0, 32'd2, "kill");
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_DIV, "divu_9_3_after_kill", 1'b1, acc);
        drain();
        kill_at_ten(1'b1, 32'd0, "reset_mid");
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_DIV, "divu_9_3_after_reset", 1'b1, acc);
        drain();

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
